// File: rtl/dac_arb_pkg.sv
// Shared types and constants for the two-requester DAC arbiter.
package dac_arb_pkg;

    localparam int DAC_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    typedef logic id_t;

    localparam id_t ID_A = 1'b0;
    localparam id_t ID_B = 1'b1;

endpackage

// File: rtl/dac_arb_if.sv
// Requester and DAC-engine signal bundle; the arbiter uses the slave view.
interface dac_arb_if;
    import dac_arb_pkg::*;

    logic             req_a;
    logic [DAC_W-1:0] data_a;
    logic             ack_a;
    logic             done_a;
    logic             req_b;
    logic [DAC_W-1:0] data_b;
    logic             ack_b;
    logic             done_b;
    logic             dac_en;
    logic [DAC_W-1:0] dac_data;
    logic             dac_done;
    logic             busy;
    logic             err;

    modport master (
        output req_a, data_a, req_b, data_b, dac_done,
        input  ack_a, done_a, ack_b, done_b, dac_en, dac_data, busy, err
    );

    modport slave (
        input  req_a, data_a, req_b, data_b, dac_done,
        output ack_a, done_a, ack_b, done_b, dac_en, dac_data, busy, err
    );

endinterface

// File: rtl/dac_arb_rr.sv
// Two-way round-robin picker: on contention, grant the side not served last.
module dac_arb_rr
    import dac_arb_pkg::*;
(
    input  logic i_req_a,
    input  logic i_req_b,
    input  id_t  i_last,
    output id_t  o_grant
);

    always_comb begin
        o_grant = ID_A;
        if (i_req_a && i_req_b) begin
            o_grant = (i_last == ID_A) ? ID_B : ID_A;
        end else if (i_req_b) begin
            o_grant = ID_B;
        end
    end

endmodule

// File: rtl/dac_arbiter.sv
// Arbitrates two requesters onto one DAC serial engine with an enforced idle gap.
// Define DAC_ARB_TIMEOUT_EN to add the WAIT timeout counter and sticky err flag.
module dac_arbiter
    import dac_arb_pkg::*;
#(
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic      clk_50mhz,
    input  logic      rst_n,
    dac_arb_if.slave  bus
);

    localparam logic [7:0] GAP_LOAD   = 8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam state_t     AFTER_DONE = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

    generate
        if (GAP_CYCLES < 0 || GAP_CYCLES > 255 || TIMEOUT_CYCLES < 1) begin : g_bad_param
            $error("dac_arbiter: parameter out of range");
        end
    endgenerate

    state_t           r_state;
    id_t              r_last;
    logic [DAC_W-1:0] r_dac_data;
    logic [7:0]       r_gap_cnt;
    logic             r_ack_a;
    logic             r_ack_b;
    logic             r_done_a;
    logic             r_done_b;
    logic             r_dac_en;
    logic             r_busy;
    id_t              w_grant;
    logic             w_timeout;
    logic             w_finish;

    dac_arb_rr u_rr (
        .i_req_a (bus.req_a),
        .i_req_b (bus.req_b),
        .i_last  (r_last),
        .o_grant (w_grant)
    );

`ifdef DAC_ARB_TIMEOUT_EN
    localparam int            TW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] r_wait_cnt;
    logic          r_err;

    assign w_timeout = (r_state == ST_WAIT) && !bus.dac_done && (r_wait_cnt == TO_LAST);
    assign bus.err   = r_err;
`else
    assign w_timeout = 1'b0;
    assign bus.err   = 1'b0;
`endif

    // A transaction ends on engine completion, or on timeout when that is built in.
    assign w_finish = (r_state == ST_WAIT) && (bus.dac_done || w_timeout);

    always_ff @(posedge clk_50mhz) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_last     <= ID_B;
            r_dac_data <= '0;
            r_gap_cnt  <= '0;
            r_ack_a    <= 1'b0;
            r_ack_b    <= 1'b0;
            r_done_a   <= 1'b0;
            r_done_b   <= 1'b0;
            r_dac_en   <= 1'b0;
            r_busy     <= 1'b0;
`ifdef DAC_ARB_TIMEOUT_EN
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
`endif
        end else begin
            r_ack_a  <= 1'b0;
            r_ack_b  <= 1'b0;
            r_done_a <= 1'b0;
            r_done_b <= 1'b0;
            r_dac_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_a || bus.req_b) begin
                        r_state    <= ST_START;
                        r_busy     <= 1'b1;
                        r_last     <= w_grant;
                        r_dac_data <= (w_grant == ID_A) ? bus.data_a : bus.data_b;
                        r_ack_a    <= (w_grant == ID_A);
                        r_ack_b    <= (w_grant == ID_B);
                    end
                end
                ST_START: begin
                    r_state  <= ST_WAIT;
                    r_dac_en <= 1'b1;
`ifdef DAC_ARB_TIMEOUT_EN
                    r_wait_cnt <= '0;
`endif
                end
                ST_WAIT: begin
                    if (w_finish) begin
                        r_state   <= AFTER_DONE;
                        r_busy    <= (GAP_CYCLES != 0);
                        r_gap_cnt <= GAP_LOAD;
                        r_done_a  <= (r_last == ID_A);
                        r_done_b  <= (r_last == ID_B);
                    end
`ifdef DAC_ARB_TIMEOUT_EN
                    else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                    if (w_timeout) begin
                        r_err <= 1'b1;
                    end
`endif
                end
                ST_GAP: begin
                    if (r_gap_cnt == '0) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ack_a    = r_ack_a;
    assign bus.ack_b    = r_ack_b;
    assign bus.done_a   = r_done_a;
    assign bus.done_b   = r_done_b;
    assign bus.dac_en   = r_dac_en;
    assign bus.dac_data = r_dac_data;
    assign bus.busy     = r_busy;

endmodule

// File: tb/tb_dac_arbiter.sv
// Directed self-checking bench for dac_arbiter (GAP_CYCLES=4 and GAP_CYCLES=0 instances).
// Define DAC_ARB_TIMEOUT_EN to also exercise the WAIT timeout path.
module tb_dac_arbiter;
    import dac_arb_pkg::*;

    logic clk  = 1'b0;
    logic rstN = 1'b0;
    int   assertCount = 0;
    int   failCount   = 0;
    int   cycleCount  = 0;

    dac_arb_if bus0 ();
    dac_arb_if bus1 ();

    dac_arbiter #(.GAP_CYCLES(4), .TIMEOUT_CYCLES(16)) dut0 (
        .clk_50mhz (clk),
        .rst_n     (rstN),
        .bus       (bus0.slave)
    );

    dac_arbiter #(.GAP_CYCLES(0), .TIMEOUT_CYCLES(16)) dut1 (
        .clk_50mhz (clk),
        .rst_n     (rstN),
        .bus       (bus1.slave)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic reqA, input logic [15:0] dataA,
                                 input logic reqB, input logic [15:0] dataB);
        bus0.req_a  = reqA;
        bus0.data_a = dataA;
        bus0.req_b  = reqB;
        bus0.data_b = dataB;
    endtask

    task automatic applyReset;
        rstN = 1'b0;
        tick();
        tick();
        rstN = 1'b1;
    endtask

    // Waits for dac_en on bus0, then plays the engine: dac_done engineDelay cycles after dac_en.
    task automatic serveOne(input int engineDelay, output logic grantedA,
                            output logic [15:0] word, output int enCycle);
        bit seen;
        seen     = 1'b0;
        grantedA = 1'b0;
        word     = '0;
        enCycle  = 0;
        for (int i = 0; i < 64 && !seen; i++) begin
            tick();
            if (bus0.ack_a) grantedA = 1'b1;
            if (bus0.dac_en) seen = 1'b1;
        end
        if (!seen) begin
            checkOutput("dac_en_wait", 32'd0, 32'd1);
            return;
        end
        word    = bus0.dac_data;
        enCycle = cycleCount;
        repeat (engineDelay) tick();
        bus0.dac_done = 1'b1;
        tick();
        bus0.dac_done = 1'b0;
        checkOutput(grantedA ? "done_a_pulse" : "done_b_pulse",
                    32'(grantedA ? bus0.done_a : bus0.done_b), 32'd1);
    endtask

    initial begin
        logic        g;
        logic [15:0] w;
        int          c;
        int          prevEn;
        bit          seen;

        applyStimulus(1'b0, 16'h0, 1'b0, 16'h0);
        bus0.dac_done = 1'b0;
        bus1.req_a    = 1'b0;
        bus1.data_a   = 16'h0;
        bus1.req_b    = 1'b0;
        bus1.data_b   = 16'h0;
        bus1.dac_done = 1'b0;

        // Reset state
        applyReset();
        checkOutput("rst_busy",     32'(bus0.busy),     32'd0);
        checkOutput("rst_dac_en",   32'(bus0.dac_en),   32'd0);
        checkOutput("rst_dac_data", 32'(bus0.dac_data), 32'h0);
        checkOutput("rst_ack_a",    32'(bus0.ack_a),    32'd0);
        checkOutput("rst_ack_b",    32'(bus0.ack_b),    32'd0);
        checkOutput("rst_err",      32'(bus0.err),      32'd0);
        checkOutput("rst_busy1",    32'(bus1.busy),     32'd0);

        // Single requester A: ack after 1 clk, dac_en after 2, busy drops GAP+1 after dac_done
        applyStimulus(1'b1, 16'hcaaa, 1'b0, 16'h0);
        tick();
        checkOutput("t1_ack_a",  32'(bus0.ack_a),  32'd1);
        checkOutput("t1_en_lo",  32'(bus0.dac_en), 32'd0);
        checkOutput("t1_busy",   32'(bus0.busy),   32'd1);
        applyStimulus(1'b0, 16'h0, 1'b0, 16'h0);
        tick();
        checkOutput("t1_dac_en",   32'(bus0.dac_en),   32'd1);
        checkOutput("t1_dac_data", 32'(bus0.dac_data), 32'hcaaa);
        checkOutput("t1_ack_drop", 32'(bus0.ack_a),    32'd0);
        tick();
        checkOutput("t1_en_once",  32'(bus0.dac_en),   32'd0);
        checkOutput("t1_data_hold", 32'(bus0.dac_data), 32'hcaaa);
        bus0.dac_done = 1'b1;
        tick();
        bus0.dac_done = 1'b0;
        checkOutput("t1_done_a", 32'(bus0.done_a), 32'd1);
        checkOutput("t1_done_b", 32'(bus0.done_b), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("t1_gap_busy", 32'(bus0.busy), 32'd1);
        end
        tick();
        checkOutput("t1_idle_busy", 32'(bus0.busy), 32'd0);

        // Both held high from reset: A,B,A,B with spacing engine(2)+GAP(4)+3 = 9
        applyReset();
        applyStimulus(1'b1, 16'h1234, 1'b1, 16'habcd);
        prevEn = 0;
        for (int k = 0; k < 4; k++) begin
            serveOne(2, g, w, c);
            checkOutput("rr_grant_a", 32'(g), (k % 2 == 0) ? 32'd1 : 32'd0);
            checkOutput("rr_word",    32'(w), (k % 2 == 0) ? 32'h1234 : 32'habcd);
            if (k > 0) checkOutput("rr_spacing", 32'(c - prevEn), 32'd9);
            prevEn = c;
        end
        applyStimulus(1'b0, 16'h0, 1'b0, 16'h0);
        repeat (8) tick();
        checkOutput("rr_idle", 32'(bus0.busy), 32'd0);

        // Reset during WAIT aborts without a done pulse
        applyReset();
        applyStimulus(1'b1, 16'h5555, 1'b0, 16'h0);
        tick();
        checkOutput("rw_ack_a", 32'(bus0.ack_a), 32'd1);
        applyStimulus(1'b0, 16'h0, 1'b0, 16'h0);
        tick();
        checkOutput("rw_dac_en", 32'(bus0.dac_en), 32'd1);
        tick();
        rstN = 1'b0;
        tick();
        rstN = 1'b1;
        checkOutput("rw_busy",     32'(bus0.busy),     32'd0);
        checkOutput("rw_dac_en0",  32'(bus0.dac_en),   32'd0);
        checkOutput("rw_dac_data", 32'(bus0.dac_data), 32'h0);
        checkOutput("rw_done_a",   32'(bus0.done_a),   32'd0);
        bus0.dac_done = 1'b1;
        tick();
        bus0.dac_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("rw_no_done", 32'(bus0.done_a), 32'd0);
            tick();
        end
        checkOutput("rw_still_idle", 32'(bus0.busy), 32'd0);
        applyStimulus(1'b0, 16'h0, 1'b1, 16'hbeef);
        serveOne(2, g, w, c);
        checkOutput("rw_grant_b", 32'(g), 32'd0);
        checkOutput("rw_word_b",  32'(w), 32'hbeef);
        applyStimulus(1'b0, 16'h0, 1'b0, 16'h0);
        repeat (8) tick();

        // GAP_CYCLES=0 instance: stray dac_done ignored, next START 2 clks after dac_done
        bus1.dac_done = 1'b1;
        tick();
        bus1.dac_done = 1'b0;
        checkOutput("g0_busy",   32'(bus1.busy),   32'd0);
        checkOutput("g0_done_a", 32'(bus1.done_a), 32'd0);
        checkOutput("g0_done_b", 32'(bus1.done_b), 32'd0);
        checkOutput("g0_dac_en", 32'(bus1.dac_en), 32'd0);
        bus1.req_a  = 1'b1;
        bus1.data_a = 16'h1111;
        bus1.req_b  = 1'b1;
        bus1.data_b = 16'h2222;
        seen = 1'b0;
        for (int i = 0; i < 16 && !seen; i++) begin
            tick();
            if (bus1.ack_a) seen = 1'b1;
        end
        checkOutput("g0_ack_a", 32'(seen), 32'd1);
        tick();
        checkOutput("g0_en_a",   32'(bus1.dac_en),   32'd1);
        checkOutput("g0_data_a", 32'(bus1.dac_data), 32'h1111);
        bus1.dac_done = 1'b1;
        tick();
        bus1.dac_done = 1'b0;
        checkOutput("g0_done_pulse", 32'(bus1.done_a), 32'd1);
        checkOutput("g0_idle",       32'(bus1.busy),   32'd0);
        tick();
        checkOutput("g0_ack_b",  32'(bus1.ack_b), 32'd1);
        bus1.req_a = 1'b0;
        bus1.req_b = 1'b0;
        tick();
        checkOutput("g0_en_b",   32'(bus1.dac_en),   32'd1);
        checkOutput("g0_data_b", 32'(bus1.dac_data), 32'h2222);

`ifdef DAC_ARB_TIMEOUT_EN
        // Engine never answers: err and done after 16 WAIT clocks, err sticky until reset
        applyReset();
        applyStimulus(1'b1, 16'h7777, 1'b0, 16'h0);
        tick();
        applyStimulus(1'b0, 16'h0, 1'b0, 16'h0);
        tick();
        checkOutput("to_dac_en", 32'(bus0.dac_en), 32'd1);
        repeat (15) tick();
        checkOutput("to_err_early",  32'(bus0.err),    32'd0);
        checkOutput("to_done_early", 32'(bus0.done_a), 32'd0);
        tick();
        checkOutput("to_err",    32'(bus0.err),    32'd1);
        checkOutput("to_done_a", 32'(bus0.done_a), 32'd1);
        repeat (10) tick();
        checkOutput("to_err_sticky", 32'(bus0.err),  32'd1);
        checkOutput("to_idle",       32'(bus0.busy), 32'd0);
        applyReset();
        checkOutput("to_err_clear", 32'(bus0.err), 32'd0);
`else
        checkOutput("err_tied", 32'(bus0.err), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/dac_arbiter.md
DAC_ARBITER -- requirements
Module: dac_arbiter

Interface
REQ-001 The block SHALL have exactly one clock and one reset: clock clk_50mhz; reset rst_n, synchronous and active-low.
REQ-002 The block SHALL have parameter GAP_CYCLES, default 4: idle clocks enforced between consecutive DAC transactions (range 0..255).
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 1023: maximum WAIT clocks before abort (used only with DAC_ARB_TIMEOUT_EN).
REQ-004 The block SHALL have the following ports (name, direction, width, meaning):
 clk_50mhz  in  1  system clock
 rst_n  in  1  synchronous active-low reset
 req_a  in  1  requester A wants a conversion (level)
 data_a  in  16  requester A DAC word
 ack_a  out  1  one-cycle pulse; data_a latched
 done_a  out  1  one-cycle pulse; A's transaction finished
 req_b  in  1  requester B wants a conversion (level)
 data_b  in  16  requester B DAC word
 ack_b  out  1  one-cycle pulse; data_b latched
 done_b  out  1  one-cycle pulse; B's transaction finished
 dac_en  out  1  one-cycle start pulse to the dac serial engine
 dac_data  out  16  word to the dac engine
 dac_done  in  1  dac engine completion pulse
 busy  out  1  high in any state except IDLE
 err  out  1  sticky timeout flag

Function
REQ-005 The FSM SHALL have states IDLE, START, WAIT and GAP.
REQ-006 In IDLE with any req high, the FSM SHALL move to START on the next edge, latch the winner's data into dac_data, and pulse the winner's ack in that same registered cycle.
REQ-007 Arbitration SHALL be round-robin: if both requests are high, the grant SHALL go to the requester not granted last; after reset, A SHALL have priority.
REQ-008 In START, dac_en SHALL be high for exactly one cycle, after which the FSM SHALL enter WAIT.
REQ-009 dac_data SHALL hold stable from START through the end of WAIT.
REQ-010 In WAIT, on dac_done=1 the block SHALL pulse the granted requester's done one cycle later and enter GAP, or IDLE when GAP_CYCLES=0.
REQ-011 GAP SHALL last exactly GAP_CYCLES clocks, after which the FSM SHALL return to IDLE.
REQ-012 dac_done seen outside WAIT SHALL be ignored.
REQ-013 req is level-sensitive: a request still high when the FSM returns to IDLE SHALL be treated as a new request.
REQ-014 Requests arriving while busy SHALL wait; they SHALL NOT be lost while held high.
REQ-015 Latency from req sampled in IDLE to dac_en high SHALL be 2 clocks.
REQ-016 Minimum spacing between successive dac_en pulses SHALL be the dac engine time plus GAP_CYCLES plus 3 clocks.

Reset
REQ-017 With rst_n=0 at a clock edge, the FSM SHALL go to IDLE; ack_a, ack_b, done_a, done_b, dac_en, busy and err SHALL be 0; dac_data SHALL be 16'h0000; the last-grant pointer SHALL select B (so A wins first).
REQ-018 A reset during START, WAIT or GAP SHALL abort the transaction with no done pulse.

Configuration
REQ-019 With DAC_ARB_TIMEOUT_EN defined, a WAIT counter SHALL run; after TIMEOUT_CYCLES clocks without dac_done, err SHALL be set sticky, the granted requester's done SHALL pulse, and the FSM SHALL enter GAP.
REQ-020 With DAC_ARB_TIMEOUT_EN defined, err SHALL clear only on reset.
REQ-021 Without DAC_ARB_TIMEOUT_EN, WAIT SHALL wait indefinitely, err SHALL be tied 0, and no counter logic SHALL be present.

Structure
REQ-022 Package dac_arb_pkg SHALL hold the FSM state encoding, the requester ID constants (ID_A, ID_B) and the DAC word width constant (16).
REQ-023 Sub-module dac_arb_rr SHALL hold the 2-way round-robin picker (inputs: req pair, last grant; output: grant ID); all other logic SHALL be inline.

Verification
REQ-024 Bench: req_a=1 only, data_a=16'hcaaa -> ack_a 1 clk later, dac_en 2 clks later with dac_data=16'hcaaa; dac_done -> done_a pulse, busy low after GAP_CYCLES+1.
REQ-025 Bench: req_a and req_b high in the same cycle after reset, data 16'h1234/16'habcd -> A served first, then B; dac_data sequence 16'h1234, 16'habcd.
REQ-026 Bench: both held high for 4 transactions -> grant order A,B,A,B; dac_en pulses spaced per REQ-016.
REQ-027 Bench: rst_n low for 1 clk during WAIT -> all outputs 0 next clock, no done pulse, next req_b served normally.
REQ-028 Bench: DAC_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, dac_done never asserted -> err=1 and done pulse after 16 WAIT clocks; err remains 1 until reset.
REQ-029 Bench: GAP_CYCLES=0 with dac_done pulsed in IDLE -> dac_done ignored; back-to-back requests give START 2 clks after done.
